// File: rtl/cacheline_req_driver.sv
// Purpose: buffers domain-tagged requests, issues them one at a time to a cacheline, tracks monitored-domain hitmap and hit/miss counts.
// Latency: 2 cycles from enqueue into an idle, empty block to req_valid; response effects visible the cycle after resp_valid.
// Backpressure: in_ready drops while the FIFO is full; req_* held stable while req_valid && !req_ready.

// Purpose: small generic synchronous FIFO with a combinational head view.
// Latency: a written entry is visible at the head the cycle after the write edge.
// Backpressure: wr_rdy is !full and does not account for a same-cycle pop.
module cacheline_req_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         wr_rdy,
  input  logic         rd_pop,
  output logic [W-1:0] rd_dat,
  output logic         rd_vld
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         full;
  logic         empty;
  logic         do_wr;
  logic         do_rd;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_rdy = !full;
  assign rd_vld = !empty;
  assign rd_dat = mem[rd_ptr[AW-1:0]];
  assign do_wr  = wr_vld && !full;
  assign do_rd  = rd_pop && !empty;

  // Pointer update; pointers wrap naturally through the extra bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is cleared on reset so the head view reads zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
  end

endmodule

// Purpose: request-side driver for one cacheline copy, with monitored-domain hitmap and saturating counters.
// Latency: enqueue->req_valid 2 cycles; one request per 2 cycles when responses come right after the handshake.
// Backpressure: upstream via in_ready (FIFO not full); downstream waits in ISSUE until req_ready.
module cacheline_req_driver #(
  parameter int WAYS    = 8,
  parameter int TAG_W   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_domain,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic                     req_domain,
  output logic [TAG_W-1:0]         req_tag,
  input  logic                     resp_valid,
  input  logic                     resp_hit,
  input  logic [$clog2(WAYS)-1:0]  resp_way,
  input  logic                     mon_domain,
  input  logic                     hitmap_clr,
  output logic [WAYS-1:0]          hitmap,
  output logic [15:0]              hit_cnt,
  output logic [15:0]              miss_cnt,
  output logic                     busy,
  output logic                     err
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic             dom;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  req_t              wr_req;
  req_t              head;
  logic              head_vld;
  logic              push;
  logic              fifo_pop;
  logic              resp_take;
  logic              timeout;
  logic              cur_dom;
  logic [TCNT_W-1:0] tcnt_q;

  assign wr_req = '{dom: in_domain, tag: in_tag};
  assign push   = in_valid && in_ready;

  cacheline_req_fifo #(
    .W     ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (in_valid),
    .wr_dat (wr_req),
    .wr_rdy (in_ready),
    .rd_pop (fifo_pop),
    .rd_dat (head),
    .rd_vld (head_vld)
  );

  assign req_domain = head.dom;
  assign req_tag    = head.tag;
  assign busy       = (state_q != S_IDLE) || head_vld;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and handshake decode; a response wins over a timeout in the same cycle.
  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    fifo_pop  = 1'b0;
    resp_take = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (head_vld) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        req_valid = 1'b1;
        if (req_ready) begin
          fifo_pop = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (resp_valid) begin
          resp_take = 1'b1;
          // Include this cycle's enqueue so a request arriving now is not delayed by an IDLE hop.
          state_d   = (head_vld || push) ? S_ISSUE : S_IDLE;
        end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the domain of the issued request and count WAIT cycles since the handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_dom <= 1'b0;
      tcnt_q  <= '0;
    end else if (fifo_pop) begin
      cur_dom <= head.dom;
      tcnt_q  <= '0;
    end else if (state_q == S_WAIT && !resp_valid && !timeout) begin
      tcnt_q  <= tcnt_q + TCNT_W'(1);
    end
  end

  // Sticky error: timeout or a response arriving when none is outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (timeout || (resp_valid && state_q != S_WAIT)) begin
      err <= 1'b1;
    end
  end

  // Saturating hit and miss counters; they update even when the hitmap is being cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (resp_take) begin
      if (resp_hit) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end

  // Hitmap: clear wins; a hit marks the way for the monitored domain, a refill leaves it set only for that domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hitmap <= '0;
    end else if (hitmap_clr) begin
      hitmap <= '0;
    end else if (resp_take) begin
      if (resp_hit) begin
        if (cur_dom == mon_domain) hitmap[resp_way] <= 1'b1;
      end else begin
        hitmap[resp_way] <= (cur_dom == mon_domain);
      end
    end
  end

endmodule

// File: tb/tb_cacheline_req_driver.sv
// Bench for cacheline_req_driver: directed scenarios plus a queue-based reference model checked every cycle.
// Inputs change 1 time unit after the rising edge; outputs and the model are evaluated on the falling edge.
module tb_cacheline_req_driver;
  localparam int WAYS    = 8;
  localparam int TAG_W   = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid, in_ready, in_domain;
  logic [TAG_W-1:0]  in_tag;
  logic              req_valid, req_ready, req_domain;
  logic [TAG_W-1:0]  req_tag;
  logic              resp_valid, resp_hit;
  logic [2:0]        resp_way;
  logic              mon_domain, hitmap_clr;
  logic [WAYS-1:0]   hitmap;
  logic [15:0]       hit_cnt, miss_cnt;
  logic              busy, err;

  int total = 0;
  int bad   = 0;

  cacheline_req_driver #(
    .WAYS(WAYS), .TAG_W(TAG_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_domain(in_domain), .in_tag(in_tag),
    .req_valid(req_valid), .req_ready(req_ready), .req_domain(req_domain), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .mon_domain(mon_domain), .hitmap_clr(hitmap_clr),
    .hitmap(hitmap), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, one outstanding request, expected registered outputs.
  logic [16:0] m_q[$];
  bit          m_out  = 1'b0;
  logic        m_dom  = 1'b0;
  int          m_wait = 0;
  logic [7:0]  m_hm   = '0;
  logic [15:0] m_hit  = '0;
  logic [15:0] m_miss = '0;
  logic        m_err  = 1'b0;

  always @(negedge clk) begin
    bit push;
    if (!rst) begin
      m_q.delete();
      m_out = 0; m_wait = 0; m_hm = '0; m_hit = '0; m_miss = '0; m_err = 1'b0;
      chk("rst_in_ready",   in_ready,   1);
      chk("rst_req_valid",  req_valid,  0);
      chk("rst_req_domain", req_domain, 0);
      chk("rst_req_tag",    req_tag,    0);
      chk("rst_hitmap",     hitmap,     0);
      chk("rst_hit_cnt",    hit_cnt,    0);
      chk("rst_miss_cnt",   miss_cnt,   0);
      chk("rst_busy",       busy,       0);
      chk("rst_err",        err,        0);
    end else begin
      chk("in_ready", in_ready, (m_q.size() < DEPTH));
      chk("busy",     busy,     (m_out || m_q.size() != 0));
      chk("hitmap",   hitmap,   m_hm);
      chk("hit_cnt",  hit_cnt,  m_hit);
      chk("miss_cnt", miss_cnt, m_miss);
      chk("err",      err,      m_err);
      push = in_valid && (m_q.size() < DEPTH);
      if (req_valid && req_ready) begin
        if (m_q.size() == 0) begin
          total++; bad++;
          $display("FAIL issue_empty: request issued with model queue empty at %0t", $time);
        end else begin
          chk("req_domain", req_domain, m_q[0][16]);
          chk("req_tag",    req_tag,    m_q[0][15:0]);
          m_dom = m_q[0][16];
          void'(m_q.pop_front());
        end
        m_out = 1; m_wait = 0;
        if (resp_valid) m_err = 1'b1;
      end else if (m_out) begin
        if (resp_valid) begin
          if (resp_hit) begin
            if (m_hit != 16'hFFFF) m_hit++;
            if (m_dom == mon_domain) m_hm[resp_way] = 1'b1;
          end else begin
            if (m_miss != 16'hFFFF) m_miss++;
            m_hm[resp_way] = (m_dom == mon_domain);
          end
          m_out = 0;
        end else begin
          m_wait++;
          if (m_wait == TIMEOUT) begin m_err = 1'b1; m_out = 0; end
        end
      end else if (resp_valid) begin
        m_err = 1'b1;
      end
      if (hitmap_clr) m_hm = '0;
      if (push) m_q.push_back({in_domain, in_tag});
    end
  end

  // One clock step; an offered input that was accepted at this edge is withdrawn.
  task automatic tick();
    logic acc;
    acc = in_valid && in_ready;
    @(posedge clk); #1;
    if (acc) in_valid = 1'b0;
  endtask

  task automatic enq(input logic dom, input logic [15:0] tag);
    int n = 0;
    in_valid = 1'b1; in_domain = dom; in_tag = tag;
    while (in_valid && n < 50) begin tick(); n++; end
    chk("enq_accept", in_valid, 0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!req_valid && n < 50) begin tick(); n++; end
    chk("req_seen", req_valid, 1);
  endtask

  // Wait for the head request, handshake it, then answer in the first WAIT cycle.
  task automatic serve(input logic hit, input logic [2:0] way, input logic [15:0] exp_tag, input logic clr);
    wait_req();
    chk("serve_tag", req_tag, exp_tag);
    tick();
    resp_valid = 1'b1; resp_hit = hit; resp_way = way; hitmap_clr = clr;
    tick();
    resp_valid = 1'b0; hitmap_clr = 1'b0;
  endtask

  initial begin
    in_valid = 1'b1; in_domain = 1'b1; in_tag = 16'h1234;
    req_ready = 1'b0; resp_valid = 1'b0; resp_hit = 1'b0; resp_way = '0;
    mon_domain = 1'b1; hitmap_clr = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Release reset with the first request already offered: accepted at the next edge.
    in_domain = 1'b1; in_tag = 16'h00AB; req_ready = 1'b1; rst = 1'b1;
    tick();
    chk("lat1_accepted",  in_valid,  0);
    chk("lat1_req_valid", req_valid, 0);
    tick();
    chk("lat2_req_valid", req_valid, 1);
    chk("lat2_req_tag",   req_tag,   16'h00AB);
    serve(1'b1, 3'd5, 16'h00AB, 1'b0);
    chk("t2_hitmap",  hitmap,  8'h20);
    chk("t2_hit_cnt", hit_cnt, 1);

    // Fill the FIFO while the cacheline stalls; the fifth request waits and is not lost.
    req_ready = 1'b0;
    for (int i = 1; i <= 4; i++) enq(i[0], 16'h0100 + 16'(i));
    chk("full_in_ready", in_ready, 0);
    in_valid = 1'b1; in_domain = 1'b1; in_tag = 16'h0105;
    repeat (3) tick();
    chk("stall_pending", in_valid, 1);
    chk("stall_head",    req_tag,  16'h0101);
    req_ready = 1'b1;
    for (int i = 1; i <= 5; i++) serve(i[0], 3'(i), 16'h0100 + 16'(i), 1'b0);
    chk("t3_fifth_taken", in_valid, 0);
    chk("t3_hitmap",   hitmap,   8'h2A);
    chk("t3_hit_cnt",  hit_cnt,  4);
    chk("t3_miss_cnt", miss_cnt, 2);

    // Refill semantics on way 5.
    hitmap_clr = 1'b1; tick(); hitmap_clr = 1'b0;
    chk("t4_clr", hitmap, 8'h00);
    enq(1'b1, 16'h0200); serve(1'b1, 3'd5, 16'h0200, 1'b0);
    chk("t4_set", hitmap, 8'h20);
    enq(1'b0, 16'h0201); serve(1'b0, 3'd5, 16'h0201, 1'b0);
    chk("t4_dom0_miss",  hitmap,   8'h00);
    chk("t4_miss_cnt",   miss_cnt, 3);
    enq(1'b1, 16'h0202); serve(1'b0, 3'd5, 16'h0202, 1'b0);
    chk("t4_dom1_miss",  hitmap,   8'h20);

    // Clear in the same cycle as a monitored hit.
    enq(1'b1, 16'h0300); serve(1'b1, 3'd2, 16'h0300, 1'b1);
    chk("t5_hitmap",  hitmap,  8'h00);
    chk("t5_hit_cnt", hit_cnt, 6);

    // Timeout after 15 silent WAIT cycles, then a stray response in IDLE.
    enq(1'b1, 16'h0EEE);
    wait_req();
    tick();
    repeat (TIMEOUT - 1) tick();
    chk("t6_err_before", err,  0);
    chk("t6_busy_wait",  busy, 1);
    tick();
    chk("t6_err",        err,       1);
    chk("t6_idle",       busy,      0);
    chk("t6_req_valid",  req_valid, 0);
    resp_valid = 1'b1; resp_hit = 1'b1; resp_way = 3'd3;
    tick();
    resp_valid = 1'b0;
    chk("t6_stray_err",    err,     1);
    chk("t6_stray_hitmap", hitmap,  8'h00);
    chk("t6_stray_hits",   hit_cnt, 6);

    // Reset in the middle of a transaction discards it.
    enq(1'b1, 16'h0400);
    enq(1'b0, 16'h0401);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t7_busy", busy, 0);
    chk("t7_err",  err,  0);
    repeat (3) tick();
    chk("t7_no_req", req_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
